// File: rtl/parallel_serializer.sv
// Parallel-in/serial-out shifter: accepts a word over a valid/ready port and
// drives it out one bit per enabled clock, MSB first unless MSB_FIRST=0.
module parallel_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sr, sr_d, sr_shifted;
  logic [CW-1:0]    cnt, cnt_d;
  logic             accept;

  assign ser_valid  = (state == SHIFT);
  assign ser_last   = ser_valid && (cnt == '0);
  // A word may be taken while the previous one is leaving on its last bit.
  assign load_ready = rst_n && (!ser_valid || (ser_last && ser_en));
  assign accept     = load_valid && load_ready;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign sr_shifted = {sr[WIDTH-2:0], 1'b0};
      assign ser_out    = ser_valid && sr[WIDTH-1];
    end else begin : g_lsb
      assign sr_shifted = {1'b0, sr[WIDTH-1:1]};
      assign ser_out    = ser_valid && sr[0];
    end
  endgenerate

  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          sr_d    = load_data;
          cnt_d   = CW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (cnt != '0) begin
            cnt_d = cnt - 1'b1;
            sr_d  = sr_shifted;
          end else if (accept) begin
            sr_d    = load_data;
            cnt_d   = CW'(WIDTH - 1);
            state_d = SHIFT;
          end else begin
            sr_d    = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      sr    <= sr_d;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_parallel_serializer.sv
// Scoreboard bench for parallel_serializer: an 8-bit MSB-first instance and a
// 4-bit LSB-first instance, with expected bits queued at load time.
module tb_parallel_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, load_valid, ser_en;
  logic [7:0] load_data;
  logic       load_ready, ser_out, ser_valid, ser_last;

  logic       l_valid, l_en;
  logic [3:0] l_data;
  logic       l_ready, l_out, l_sv, l_last;

  int total = 0;
  int bad   = 0;

  logic [1:0] q8[$];
  logic [1:0] q4[$];
  logic [1:0] e8, e4;
  logic [7:0] rx_q;
  logic       h_out, h_valid, h_last;

  parallel_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .ser_en(ser_en), .ser_out(ser_out),
    .ser_valid(ser_valid), .ser_last(ser_last)
  );

  parallel_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(l_valid), .load_ready(l_ready),
    .load_data(l_data), .ser_en(l_en), .ser_out(l_out),
    .ser_valid(l_sv), .ser_last(l_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entries are {last, bit} in transmit order.
  task automatic push8(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q8.push_back({(i == 0), w[i]});
  endtask

  task automatic push4(input logic [3:0] w);
    for (int i = 0; i < 4; i++) q4.push_back({(i == 3), w[i]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Loopback receiver: serial-in shift register into the LSB.
  always @(posedge clk) begin
    if (!rst_n) rx_q <= '0;
    else if (ser_valid && ser_en) rx_q <= {rx_q[6:0], ser_out};
  end

  always @(negedge clk) begin
    if (rst_n && ser_valid && ser_en) begin
      if (q8.size() == 0) begin
        check("m8_extra_bit", 32'(ser_valid), 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("m8_bit", 32'(ser_out), 32'(e8[0]));
        check("m8_last", 32'(ser_last), 32'(e8[1]));
      end
    end else if (!ser_valid) begin
      check("m8_idle_out", 32'(ser_out), 32'd0);
      check("m8_idle_last", 32'(ser_last), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && l_sv && l_en) begin
      if (q4.size() == 0) begin
        check("m4_extra_bit", 32'(l_sv), 32'd0);
      end else begin
        e4 = q4.pop_front();
        check("m4_bit", 32'(l_out), 32'(e4[0]));
        check("m4_last", 32'(l_last), 32'(e4[1]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(ser_valid), 32'd0);
    check({tag, "_out"}, 32'(ser_out), 32'd0);
    check({tag, "_last"}, 32'(ser_last), 32'd0);
    check({tag, "_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_q8"}, 32'(q8.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; ser_en = 1'b0;
    l_valid = 1'b0; l_data = '0; l_en = 1'b0;
    tick_n(2);
    check("rst_valid", 32'(ser_valid), 32'd0);
    check("rst_out", 32'(ser_out), 32'd0);
    check("rst_last", 32'(ser_last), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(load_ready), 32'd1);

    // Single word with ser_en held high.
    tick();
    load_valid = 1'b1; load_data = 8'hB4; ser_en = 1'b1;
    #1;
    check("w1_ready", 32'(load_ready), 32'd1);
    push8(8'hB4);
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("w1_valid", 32'(ser_valid), 32'd1);
      check("w1_last_pos", 32'(ser_last), 32'(k == 7));
      tick();
    end
    check_idle("w1_end");

    // Loopback into a serial-in receiver.
    load_valid = 1'b1; load_data = 8'h0B;
    push8(8'h0B);
    tick();
    load_valid = 1'b0;
    tick_n(8);
    check("loop_rx", 32'(rx_q), 32'h0B);
    check_idle("loop_end");

    // Stall for three cycles after two bits.
    load_valid = 1'b1; load_data = 8'hA5;
    push8(8'hA5);
    tick();
    load_valid = 1'b0;
    tick_n(2);
    ser_en = 1'b0;
    h_out = ser_out; h_valid = ser_valid; h_last = ser_last;
    check("stall_bit3", 32'(h_out), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_out", 32'(ser_out), 32'(h_out));
      check("stall_valid", 32'(ser_valid), 32'(h_valid));
      check("stall_last", 32'(ser_last), 32'(h_last));
    end
    ser_en = 1'b1;
    tick_n(6);
    check_idle("stall_end");

    // Back-to-back words with load_valid held.
    load_valid = 1'b1; load_data = 8'hA5;
    push8(8'hA5);
    tick();
    load_data = 8'h3C;
    push8(8'h3C);
    #1;
    for (int k = 0; k < 8; k++) begin
      check("b2b_ready", 32'(load_ready), 32'(k == 7));
      check("b2b_valid1", 32'(ser_valid), 32'd1);
      tick();
    end
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("b2b_valid2", 32'(ser_valid), 32'd1);
      check("b2b_last2", 32'(ser_last), 32'(k == 7));
      tick();
    end
    check_idle("b2b_end");

    // Busy rejection, then reset mid-word.
    load_valid = 1'b1; load_data = 8'hFF;
    push8(8'hFF);
    tick();
    load_valid = 1'b0;
    tick_n(2);
    load_valid = 1'b1; load_data = 8'h00;
    #1;
    check("busy_ready", 32'(load_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    check("busy_out", 32'(ser_out), 32'd1);
    tick();
    rst_n = 1'b0;
    load_valid = 1'b1; load_data = 8'h5A;
    #1;
    check("rst_mid_ready", 32'(load_ready), 32'd0);
    tick();
    q8.delete();
    check("rst_mid_valid", 32'(ser_valid), 32'd0);
    check("rst_mid_out", 32'(ser_out), 32'd0);
    check("rst_mid_last", 32'(ser_last), 32'd0);
    load_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check_idle("rst_rel");
    load_valid = 1'b1; load_data = 8'h69;
    push8(8'h69);
    tick();
    load_valid = 1'b0;
    tick_n(8);
    check_idle("post_rst_end");

    // LSB-first, 4-bit instance.
    l_valid = 1'b1; l_data = 4'b0001; l_en = 1'b1;
    #1;
    check("lsb_ready", 32'(l_ready), 32'd1);
    push4(4'b0001);
    tick();
    l_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("lsb_valid", 32'(l_sv), 32'd1);
      tick();
    end
    check("lsb_end_valid", 32'(l_sv), 32'd0);
    check("lsb_q4", 32'(q4.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
